// File: rtl/cnn_sched_pkg.sv
// ----------------------------------------------------------------------------
// cnn_sched_pkg
// Shared definitions for the CNN frame scheduler: FSM state encoding and
// default frame / timeout sizing.
// ----------------------------------------------------------------------------
package cnn_sched_pkg;

  localparam int unsigned DEF_FRAME_PIXELS   = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } sched_state_e;

endpackage

// File: rtl/cnn_frame_scheduler.sv
// ----------------------------------------------------------------------------
// cnn_frame_scheduler
// Ping-pong frame-buffer scheduler feeding a CNN core. The writer fills one
// bank while the scheduler streams the other into the CNN, waits for the
// CNN result (bounded by a timeout), then releases the bank.
//
// Ports
//   sys_clk / sys_rst_n   clock, asynchronous active-low reset
//   enable                allow new frames to start
//   wr_frame_done         pulse: writer finished bank wr_bank
//   wr_bank / wr_ready    bank the writer fills next / that bank is free
//   rd_bank               bank currently streamed
//   rd_en / rd_addr       frame-buffer read port (data returns 1 cycle later)
//   pixel_valid           rd_en delayed 1 cycle, qualifies data to the CNN
//   cnn_start             one-cycle start pulse to the CNN
//   cnn_result_valid      CNN result strobe (only honoured while waiting)
//   frame_done            pulse: frame completed with a result
//   frame_count           completed-frame counter (wraps)
//   busy                  scheduler not idle
//   clear_err             clears sticky errors
//   timeout_err           sticky: CNN result never arrived
//   overflow_err          sticky: frame written while no bank was free
// ----------------------------------------------------------------------------
module cnn_frame_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS   = DEF_FRAME_PIXELS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ADDR_W         = $clog2(FRAME_PIXELS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              wr_frame_done,
  output logic              wr_bank,
  output logic              wr_ready,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pixel_valid,
  output logic              cnn_start,
  input  logic              cnn_result_valid,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              busy,
  input  logic              clear_err,
  output logic              timeout_err,
  output logic              overflow_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  // WAIT lasts exactly TIMEOUT_CYCLES cycles when no result arrives.
  localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e      r_state;
  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_cnn_start;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_pixel_valid;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic              r_timeout_err;
  logic              r_overflow_err;

  logic              w_wr_ready;
  logic              w_wr_accept;
  logic              w_release;
  logic              w_timeout_set;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;

  // Acceptance looks only at registered flags, so a bank freed in the
  // current RELEASE cycle cannot yet take a frame.
  assign w_wr_ready  = ~r_full[r_wr_bank];
  assign w_wr_accept = wr_frame_done & w_wr_ready;
  assign w_release   = (r_state == ST_RELEASE);
  assign w_full_set  = {w_wr_accept & r_wr_bank, w_wr_accept & ~r_wr_bank};
  assign w_full_clr  = {w_release & r_rd_bank, w_release & ~r_rd_bank};
  assign w_timeout_set = (r_state == ST_WAIT) && !cnn_result_valid &&
                         (r_wait_cnt == LAST_WAIT);

  // Bank bookkeeping: writer sets, scheduler clears; both in one cycle is
  // legal because they always target different banks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_full         <= 2'b00;
      r_wr_bank      <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      if (w_wr_accept)
        r_wr_bank <= ~r_wr_bank;
      if (wr_frame_done && !w_wr_ready)
        r_overflow_err <= 1'b1;
      else if (clear_err)
        r_overflow_err <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_rd_bank     <= 1'b0;
      r_wait_cnt    <= '0;
      r_cnn_start   <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnn_start   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_pixel_valid <= r_rd_en;
      case (r_state)
        ST_IDLE: begin
          if (enable && r_full[r_rd_bank]) begin
            r_state     <= ST_START;
            r_cnn_start <= 1'b1;
          end
        end
        ST_START: begin
          r_state   <= ST_STREAM;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
        end
        ST_STREAM: begin
          if (r_rd_addr == LAST_ADDR) begin
            r_state    <= ST_WAIT;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_wait_cnt <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        ST_WAIT: begin
          // A result arriving on the final wait cycle still counts as success.
          if (cnn_result_valid) begin
            r_state       <= ST_RELEASE;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_state <= ST_RELEASE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          r_rd_bank <= ~r_rd_bank;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_timeout_set)
        r_timeout_err <= 1'b1;
      else if (clear_err)
        r_timeout_err <= 1'b0;
    end
  end

  assign wr_bank      = r_wr_bank;
  assign wr_ready     = w_wr_ready;
  assign rd_bank      = r_rd_bank;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign pixel_valid  = r_pixel_valid;
  assign cnn_start    = r_cnn_start;
  assign frame_done   = r_frame_done;
  assign frame_count  = r_frame_count;
  assign busy         = (r_state != ST_IDLE);
  assign timeout_err  = r_timeout_err;
  assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_cnn_frame_scheduler
// Self-checking bench. Inputs are driven and outputs sampled on the falling
// clock edge. The reference model tracks banks as a two-entry array plus
// bank pointers and derives per-frame timing arithmetically from the cycle
// at which cnn_start is seen.
// ----------------------------------------------------------------------------
module tb_cnn_frame_scheduler;

  localparam int FP = 1024;
  localparam int TO = 100;
  localparam int AW = $clog2(FP);

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          cnn_result_valid = 1'b0;
  logic          clear_err = 1'b0;
  logic          wr_bank, wr_ready, rd_bank, rd_en, pixel_valid, cnn_start;
  logic [AW-1:0] rd_addr;
  logic          frame_done, busy, timeout_err, overflow_err;
  logic [15:0]   frame_count;

  always #5 sys_clk = ~sys_clk;

  cnn_frame_scheduler #(
    .FRAME_PIXELS  (FP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .enable          (enable),
    .wr_frame_done   (wr_frame_done),
    .wr_bank         (wr_bank),
    .wr_ready        (wr_ready),
    .rd_bank         (rd_bank),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .pixel_valid     (pixel_valid),
    .cnn_start       (cnn_start),
    .cnn_result_valid(cnn_result_valid),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .busy            (busy),
    .clear_err       (clear_err),
    .timeout_err     (timeout_err),
    .overflow_err    (overflow_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          full_m [2];
  bit          wb_m, rb_m, ovf_m, tmo_m;
  logic [15:0] fc_m;
  int          frame_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_init();
    full_m[0] = 0; full_m[1] = 0;
    wb_m = 0; rb_m = 0; ovf_m = 0; tmo_m = 0; fc_m = '0;
  endtask

  // One clock cycle: check bank/error/count outputs against the model, drive
  // this cycle's inputs, advance the model to the next cycle.
  task automatic step(input bit wr, input bit res, input bit clr,
                      input bit rel, input bit tmo_ev);
    bit new_ovf;
    chk("wr_bank", wr_bank, wb_m);
    chk("wr_ready", wr_ready, !full_m[wb_m]);
    chk("rd_bank", rd_bank, rb_m);
    chk("overflow_err", overflow_err, ovf_m);
    chk("timeout_err", timeout_err, tmo_m);
    chk("frame_count", frame_count, fc_m);
    wr_frame_done    = wr;
    cnn_result_valid = res;
    clear_err        = clr;
    new_ovf = 0;
    if (wr) begin
      if (!full_m[wb_m]) begin
        full_m[wb_m] = 1;
        wb_m = !wb_m;
      end else begin
        new_ovf = 1;
      end
    end
    if (rel) begin
      full_m[rb_m] = 0;
      rb_m = !rb_m;
    end
    ovf_m = new_ovf | (ovf_m & !clr);
    tmo_m = tmo_ev  | (tmo_m & !clr);
    @(negedge sys_clk);
    wr_frame_done    = 0;
    cnn_result_valid = 0;
    clear_err        = 0;
  endtask

  task automatic do_reset();
    sys_rst_n = 0; enable = 0;
    wr_frame_done = 0; cnn_result_valid = 0; clear_err = 0;
    #2;
    chk("rst_outputs", {wr_bank, rd_bank, rd_en, rd_addr, pixel_valid, cnn_start,
                        frame_done, frame_count, busy, timeout_err, overflow_err}, 64'd0);
    chk("rst_wr_ready", wr_ready, 1);
    model_init();
    @(negedge sys_clk);
    sys_rst_n = 1;
    @(negedge sys_clk);
  endtask

  // Run one frame. d = WAIT cycle on which the result arrives (d >= TO means
  // no result -> timeout). rnd adds random writes, clears, enable drops and a
  // stray result strobe before WAIT.
  task automatic run_frame(input int d, input bit exp_b2b, input bit rnd);
    int n, relc, tmoc, wcyc, scyc, ccyc, dcyc, bank;
    logic [4:0] exp_ctl;
    bit exp_rd;
    n = 0;
    while (cnn_start !== 1'b1 && n < 20) begin
      chk("idle_busy", busy, 0);
      step(0, 0, 0, 0, 0);
      n++;
    end
    if (cnn_start !== 1'b1) begin
      chk("start_seen", cnn_start, 1);
      return;
    end
    if (exp_b2b) chk("b2b_gap", n, 1);
    bank = rb_m;
    relc = FP + 1 + ((d < TO) ? d + 1 : TO);
    tmoc = FP + TO;
    wcyc = -1; scyc = -1; ccyc = -1; dcyc = -1;
    if (rnd) begin
      if ($urandom_range(0, 3) != 0) wcyc = $urandom_range(0, relc);
      if ($urandom_range(0, 1) == 1) scyc = $urandom_range(0, FP);
      if (d >= TO && $urandom_range(0, 1) == 1) ccyc = tmoc;
      else if ($urandom_range(0, 2) == 0) ccyc = $urandom_range(0, relc);
      if ($urandom_range(0, 4) == 0) dcyc = $urandom_range(0, relc);
    end
    for (int c = 0; c <= relc; c++) begin
      exp_rd  = (c >= 1 && c <= FP);
      exp_ctl = {c == 0, exp_rd, (c >= 2 && c <= FP + 1), 1'b1, (c == relc) && (d < TO)};
      chk("ctl{start,rd_en,pv,busy,fdone}", {cnn_start, rd_en, pixel_valid, busy, frame_done}, exp_ctl);
      if (exp_rd) chk("rd_addr", rd_addr, c - 1);
      if (c == dcyc) enable = 0;
      step(c == wcyc, (c == scyc) || (d < TO && c == FP + 1 + d), c == ccyc,
           c == relc, (d >= TO) && (c == tmoc));
      if (d < TO && c == FP + 1 + d) fc_m++;
    end
    $display("frame %0d: bank=%0d wait=%0d %s count=%0d", frame_idx, bank, d,
             (d < TO) ? "result" : "timeout", fc_m);
    frame_idx++;
  endtask

  initial begin
    int d, n, fd_seen;
    bit b2b;
    model_init();
    @(negedge sys_clk);
    do_reset();

    // Frame written while disabled: scheduler must stay idle, stray result ignored.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("disabled_idle", {busy, cnn_start, frame_done}, 3'b000);
      step(0, i == 4, 0, 0, 0);
    end
    // Single frame, result 10 cycles into WAIT.
    enable = 1;
    run_frame(10, 0, 0);
    chk("single_count", frame_count, 1);
    chk("single_released", wr_ready, 1);

    // Ping-pong, overflow and clear, then back-to-back frames with a timeout.
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("pp_bank1", wr_bank, 1);
    repeat (4) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pp_bank0", wr_bank, 0);
    chk("pp_not_ready", wr_ready, 0);
    step(1, 0, 0, 0, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_flags_kept", {wr_bank, wr_ready}, 2'b00);
    step(0, 0, 1, 0, 0);
    chk("ovf_cleared", overflow_err, 0);
    enable = 1;
    run_frame($urandom_range(0, TO - 1), 0, 0);
    run_frame(TO + 5, 1, 0);
    chk("tmo_set", timeout_err, 1);
    chk("tmo_count_kept", frame_count, 1);
    chk("tmo_no_fdone", frame_done, 0);

    // Randomized traffic.
    for (int i = 0; i < 14; i++) begin
      b2b = (enable == 1'b1) && full_m[rb_m];
      if (enable == 1'b0) begin
        for (int k = 0; k < 5; k++) begin
          chk("en_low_idle", {busy, cnn_start}, 2'b00);
          step(0, 0, 0, 0, 0);
        end
        enable = 1;
      end
      if (!full_m[rb_m]) step(1, 0, 0, 0, 0);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 20) : $urandom_range(0, TO - 1);
      run_frame(d, b2b, 1);
    end

    // Reset in the middle of streaming.
    enable = 1;
    if (!full_m[rb_m]) step(1, 0, 0, 0, 0);
    n = 0;
    while (cnn_start !== 1'b1 && n < 20) begin
      step(0, 0, 0, 0, 0);
      n++;
    end
    chk("rst_run_start", cnn_start, 1);
    repeat (501) step(0, 0, 0, 0, 0);
    chk("pre_rst_addr", rd_addr, 500);
    do_reset();
    enable = 1;
    fd_seen = 0;
    for (int k = 0; k < FP + 200; k++) begin
      fd_seen += frame_done;
      step(0, 0, 0, 0, 0);
    end
    chk("no_fdone_after_rst", fd_seen, 0);
    chk("idle_after_rst", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_frame_scheduler.md
CNN_FRAME_SCHEDULER -- requirements
Module: cnn_frame_scheduler

Interface
REQ-001 Parameters SHALL be: FRAME_PIXELS, 1024, pixels per frame; TIMEOUT_CYCLES, 65535, max wait for a CNN result; ADDR_W, $clog2(FRAME_PIXELS), read address width.
REQ-002 The block SHALL use one clock, sys_clk, and an asynchronous active-low reset, sys_rst_n.
REQ-003 Ports SHALL be exactly:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  async active-low reset
- enable  in  1  allow new frames to start
- wr_frame_done  in  1  one-cycle pulse; writer finished the bank on wr_bank (sys_clk domain)
- wr_bank  out  1  ping-pong bank the writer fills next
- wr_ready  out  1  wr_bank is free
- rd_bank  out  1  bank being streamed
- rd_en  out  1  frame-buffer read enable; data returns 1 cycle later
- rd_addr  out  ADDR_W  frame-buffer read address
- pixel_valid  out  1  rd_en delayed 1 cycle, aligned with buffer data to the CNN
- cnn_start  out  1  one-cycle start pulse to the CNN core
- cnn_result_valid  in  1  CNN final result strobe
- frame_done  out  1  one-cycle pulse, frame completed with a result
- frame_count  out  16  completed-frame counter, wraps at 65535->0
- busy  out  1  state != IDLE
- clear_err  in  1  clears sticky errors
- timeout_err  out  1  sticky, result never arrived
- overflow_err  out  1  sticky, wr_frame_done while no bank free

Function
REQ-004 Bank tracking SHALL use two full flags; wr_ready = !full[wr_bank].
REQ-005 An accepted wr_frame_done (wr_ready=1) SHALL set full[wr_bank] and toggle wr_bank on the next edge.
REQ-006 wr_frame_done with wr_ready=0 SHALL be dropped and set overflow_err; wr_ready is evaluated on the registered value, even if a bank frees in the same cycle.
REQ-007 FSM states SHALL be IDLE, START, STREAM, WAIT, RELEASE.
REQ-008 IDLE->START when enable=1 and full[rd_bank]=1; otherwise stay in IDLE.
REQ-009 START SHALL assert cnn_start for exactly one cycle, then go to STREAM with rd_addr=0.
REQ-010 STREAM SHALL assert rd_en every cycle, incrementing rd_addr from 0 to FRAME_PIXELS-1; after the last address it SHALL go to WAIT with rd_en=0.
REQ-011 Latency: cnn_start at cycle T, rd_en at T+1..T+FRAME_PIXELS, pixel_valid at T+2..T+FRAME_PIXELS+1; no gaps.
REQ-012 WAIT SHALL count cycles from 0; on cnn_result_valid go to RELEASE (success); when the count reaches TIMEOUT_CYCLES go to RELEASE and set timeout_err.
REQ-013 cnn_result_valid outside WAIT SHALL be ignored.
REQ-014 RELEASE SHALL clear full[rd_bank], toggle rd_bank and return to IDLE; on success it SHALL also pulse frame_done and increment frame_count.
REQ-015 A wr_frame_done in the RELEASE cycle targets the other bank; both flag updates SHALL take effect.
REQ-016 Deasserting enable SHALL only block the IDLE->START transition; an in-flight frame completes.
REQ-017 clear_err SHALL clear both sticky errors; a new error in the same cycle SHALL win.
REQ-018 Back-to-back frames: with the other bank full at RELEASE, the next cnn_start SHALL occur 2 cycles after RELEASE (IDLE, then START).

Reset
REQ-019 Reset SHALL force the state to IDLE, clear full[1:0], set wr_bank=0 and rd_bank=0, and zero rd_addr and the timeout counter.
REQ-020 Reset SHALL drive all outputs to 0, except wr_ready=1.
REQ-021 Reset during STREAM or WAIT SHALL abandon the frame with no frame_done.

Structure
REQ-022 Package cnn_sched_pkg SHALL hold the FSM state enum and the default FRAME_PIXELS/TIMEOUT_CYCLES constants.
REQ-023 The block SHALL be a single module with no sub-module; the frame buffer and the CNN core stay outside.

Verification
REQ-024 Single frame: reset, wr_frame_done, enable=1 -> cnn_start once; 1024 rd_en with addr 0..1023; pixel_valid lags by 1; result at WAIT+10 -> frame_done, frame_count=1, full[0]=0.
REQ-025 Ping-pong: two wr_frame_done 5 cycles apart -> wr_bank 0->1->0, wr_ready=0 after the second; frames stream from bank 0 then bank 1, with the second cnn_start 2 cycles after the first RELEASE.
REQ-026 Overflow: third wr_frame_done with both banks full -> overflow_err=1, full flags unchanged; clear_err -> overflow_err=0.
REQ-027 Timeout: TIMEOUT_CYCLES=100, no result -> timeout_err=1 100 cycles into WAIT, bank released, no frame_done, frame_count unchanged.
REQ-028 Reset at rd_addr=500 -> all outputs at reset values immediately (async); no frame_done afterwards.
REQ-029 enable=0 with a full bank -> stays in IDLE, busy=0; a result strobe while IDLE is ignored.
